// File: rtl/serpent_pkg.sv
// Serpent constants, state encoding and datapath helpers shared by the round engine.
// S-boxes act bitsliced across the four 32-bit words {x3,x2,x1,x0}.
package serpent_pkg;
    localparam int NUM_ROUNDS = 32;
    localparam int NUM_KEYS   = 33;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Linear transform rotate/shift amounts, listed in application order.
    localparam int LT_ROT_A0 = 13;
    localparam int LT_ROT_A2 = 3;
    localparam int LT_SHL_A0 = 3;
    localparam int LT_ROT_B1 = 1;
    localparam int LT_ROT_B3 = 7;
    localparam int LT_SHL_B1 = 7;
    localparam int LT_ROT_C0 = 5;
    localparam int LT_ROT_C2 = 22;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Bit i of each word forms one nibble, x0 supplying the LSB.
    function automatic logic [127:0] sbox_layer(input logic [2:0] sel, input logic [127:0] x);
        logic [127:0] y;
        logic [3:0]   nib;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            nib        = SBOX[sel][{x[96+i], x[64+i], x[32+i], x[i]}];
            y[i]       = nib[0];
            y[32+i]    = nib[1];
            y[64+i]    = nib[2];
            y[96+i]    = nib[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lin_transform(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = x;
        x0 = rotl(x0, LT_ROT_A0);
        x2 = rotl(x2, LT_ROT_A2);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << LT_SHL_A0);
        x1 = rotl(x1, LT_ROT_B1);
        x3 = rotl(x3, LT_ROT_B3);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << LT_SHL_B1);
        x0 = rotl(x0, LT_ROT_C0);
        x2 = rotl(x2, LT_ROT_C2);
        return {x3, x2, x1, x0};
    endfunction
endpackage

// File: rtl/serpent_round.sv
// One combinational Serpent round: key mix, S-box chosen by round index, then LT,
// or for the last round a second key mix with K32 in place of LT.
module serpent_round (
    input  logic [127:0] x,
    input  logic [127:0] key,
    input  logic [127:0] key_last,
    input  logic [4:0]   round,
    output logic [127:0] y
);
    import serpent_pkg::*;

    logic [127:0] s_out;

    always_comb begin
        s_out = sbox_layer(round[2:0], x ^ key);
        if (round == 5'd31) begin
            y = s_out ^ key_last;
        end else begin
            y = lin_transform(s_out);
        end
    end
endmodule

// File: rtl/serpent_round_engine.sv
// Iterative Serpent encryption engine, UNROLL rounds per clock (1, 2, 4 or 8).
// Define SERPENT_KEY_LATCH_EN to capture the round keys on acceptance; otherwise keys are used live.
module serpent_round_engine
    import serpent_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] keys [0:NUM_KEYS-1],
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam logic [4:0] STEP     = 5'(UNROLL);
    localparam logic [4:0] LAST_CTR = 5'(NUM_ROUNDS - UNROLL);

    state_t                     state;
    logic [4:0]                 round_ctr;
    logic [127:0]               data_reg;
    logic [127:0]               round_keys [0:NUM_KEYS-1];
    logic [UNROLL:0][127:0]     chain;
    logic                       accept;

    assign accept = (state == IDLE) && in_valid && in_ready;

`ifdef SERPENT_KEY_LATCH_EN
    logic [127:0] key_reg [0:NUM_KEYS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) key_reg[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_KEYS; i++) key_reg[i] <= keys[i];
        end
    end

    assign round_keys = key_reg;
`else
    assign round_keys = keys;
`endif

    // Counter stays a multiple of UNROLL, so the chained indices never pass 31 in one cycle.
    assign chain[0] = data_reg;
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [4:0] idx;
        assign idx = round_ctr + 5'(u);
        serpent_round u_round (
            .x        (chain[u]),
            .key      (round_keys[idx]),
            .key_last (round_keys[NUM_KEYS-1]),
            .round    (idx),
            .y        (chain[u+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_ctr <= '0;
            data_reg  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_reg  <= in_data;
                        round_ctr <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    data_reg  <= chain[UNROLL];
                    round_ctr <= round_ctr + STEP;
                    if (round_ctr == LAST_CTR) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_data = (state == DONE) ? data_reg : '0;
endmodule
